// File: rtl/npu_dispatch_if.sv
// Command/response bus between the EX-stage dispatcher and the NPU.
// The master side issues commands and the slave side reports completion.
interface npu_dispatch_if;
    logic        npu_cmd_valid;
    logic        npu_cmd_ready;
    logic [1:0]  npu_cmd_op;
    logic [63:0] npu_cmd_src;
    logic [63:0] npu_cmd_dst;
    logic        npu_done;
    logic        npu_error;
    logic [63:0] npu_result;

    modport master (
        output npu_cmd_valid, npu_cmd_op, npu_cmd_src, npu_cmd_dst,
        input  npu_cmd_ready, npu_done, npu_error, npu_result
    );

    modport slave (
        input  npu_cmd_valid, npu_cmd_op, npu_cmd_src, npu_cmd_dst,
        output npu_cmd_ready, npu_done, npu_error, npu_result
    );
endinterface

// File: rtl/npu_dispatch.sv
// Dispatches NPU matmul/conv instructions from EX, stalls the front-end until the
// NPU completes or times out, then issues a single register-file writeback.
module npu_dispatch #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                dec_valid,
    input  logic                is_npu_matrix_mul,
    input  logic                is_npu_conv,
    input  logic [63:0]         rs1_data,
    input  logic [63:0]         rs2_data,
    input  logic [4:0]          rd_addr,
    output logic                stall,
    npu_dispatch_if.master      npu,
    output logic                wb_valid,
    output logic [4:0]          wb_rd,
    output logic [63:0]         wb_data,
    output logic                npu_fault
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       rd_q;
    logic [63:0]      data_q;
    logic             req;

    // Both flags set is a malformed decode and is treated as no request.
    assign req   = dec_valid & (is_npu_matrix_mul ^ is_npu_conv);
    assign stall = (state != IDLE) | req;

    assign wb_rd   = rd_q;
    assign wb_data = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            cnt               <= '0;
            rd_q              <= '0;
            data_q            <= '0;
            npu.npu_cmd_valid <= 1'b0;
            npu.npu_cmd_op    <= 2'b00;
            npu.npu_cmd_src   <= '0;
            npu.npu_cmd_dst   <= '0;
            wb_valid          <= 1'b0;
            npu_fault         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        npu.npu_cmd_op    <= is_npu_matrix_mul ? 2'b01 : 2'b10;
                        npu.npu_cmd_src   <= rs1_data;
                        npu.npu_cmd_dst   <= rs2_data;
                        npu.npu_cmd_valid <= 1'b1;
                        rd_q              <= rd_addr;
                        state             <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (npu.npu_cmd_ready) begin
                        npu.npu_cmd_valid <= 1'b0;
                        cnt               <= '0;
                        state             <= WAIT;
                    end
                end
                WAIT: begin
                    // Completion takes priority over a coincident timeout.
                    if (npu.npu_done) begin
                        data_q    <= npu.npu_error ? '1 : npu.npu_result;
                        npu_fault <= npu.npu_error;
                        wb_valid  <= (rd_q != 5'd0);
                        state     <= WB;
                    end else if (cnt == CNT_LAST) begin
                        data_q    <= '1;
                        npu_fault <= 1'b1;
                        wb_valid  <= (rd_q != 5'd0);
                        state     <= WB;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WB: begin
                    wb_valid  <= 1'b0;
                    npu_fault <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_npu_dispatch.sv
// Directed bench for npu_dispatch with TIMEOUT_CYCLES = 8.
module tb_npu_dispatch;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        dec_valid, is_npu_matrix_mul, is_npu_conv;
    logic [63:0] rs1_data, rs2_data;
    logic [4:0]  rd_addr;
    logic        stall, wb_valid, npu_fault;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;

    int checks = 0;
    int errors = 0;

    npu_dispatch_if bus ();

    npu_dispatch #(.TIMEOUT_CYCLES(8)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .dec_valid         (dec_valid),
        .is_npu_matrix_mul (is_npu_matrix_mul),
        .is_npu_conv       (is_npu_conv),
        .rs1_data          (rs1_data),
        .rs2_data          (rs2_data),
        .rd_addr           (rd_addr),
        .stall             (stall),
        .npu               (bus.master),
        .wb_valid          (wb_valid),
        .wb_rd             (wb_rd),
        .wb_data           (wb_data),
        .npu_fault         (npu_fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic request(input logic mm, input logic cv, input logic [63:0] s,
                           input logic [63:0] d, input logic [4:0] rd);
        dec_valid = 1'b1; is_npu_matrix_mul = mm; is_npu_conv = cv;
        rs1_data = s; rs2_data = d; rd_addr = rd;
    endtask

    task automatic drop_request();
        dec_valid = 1'b0; is_npu_matrix_mul = 1'b0; is_npu_conv = 1'b0;
        rs1_data = 64'hDEAD_BEEF_0000_0000; rs2_data = 64'h0; rd_addr = 5'd31;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drop_request();
        bus.npu_cmd_ready = 1'b0; bus.npu_done = 1'b0;
        bus.npu_error = 1'b0; bus.npu_result = 64'h0;
        tick(); tick();
        check("rst_cmd_valid", 64'(bus.npu_cmd_valid), 64'd0);
        check("rst_wb_valid", 64'(wb_valid), 64'd0);
        check("rst_fault", 64'(npu_fault), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_op", 64'(bus.npu_cmd_op), 64'd0);
        check("rst_wb_data", wb_data, 64'd0);
        rst_n = 1'b1;

        // Matmul accepted on the first edge after reset release; done in 4th WAIT cycle.
        request(1'b1, 1'b0, 64'h1000, 64'h2000, 5'd5);
        bus.npu_cmd_ready = 1'b1;
        #1 check("mm_stall_idle_req", 64'(stall), 64'd1);
        tick();
        drop_request();
        #1;
        check("mm_cmd_valid", 64'(bus.npu_cmd_valid), 64'd1);
        check("mm_op", 64'(bus.npu_cmd_op), 64'd1);
        check("mm_src", bus.npu_cmd_src, 64'h1000);
        check("mm_dst", bus.npu_cmd_dst, 64'h2000);
        tick();
        bus.npu_cmd_ready = 1'b0;
        check("mm_valid_after_hs", 64'(bus.npu_cmd_valid), 64'd0);
        check("mm_stall_wait", 64'(stall), 64'd1);
        tick(); tick(); tick();
        check("mm_no_early_wb", 64'(wb_valid), 64'd0);
        bus.npu_done = 1'b1; bus.npu_result = 64'hABCD;
        tick();
        bus.npu_done = 1'b0;
        check("mm_wb_valid", 64'(wb_valid), 64'd1);
        check("mm_wb_rd", 64'(wb_rd), 64'd5);
        check("mm_wb_data", wb_data, 64'hABCD);
        check("mm_fault", 64'(npu_fault), 64'd0);
        check("mm_stall_wb", 64'(stall), 64'd1);
        tick();
        check("mm_wb_once", 64'(wb_valid), 64'd0);
        check("mm_stall_idle", 64'(stall), 64'd0);

        // Conv with ready held low for 3 cycles; a stray done during ISSUE is ignored.
        request(1'b0, 1'b1, 64'h3000, 64'h4000, 5'd7);
        tick();
        drop_request();
        bus.npu_done = 1'b1; bus.npu_result = 64'h1234;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("cv_valid_held", 64'(bus.npu_cmd_valid), 64'd1);
            check("cv_op", 64'(bus.npu_cmd_op), 64'd2);
            check("cv_src", bus.npu_cmd_src, 64'h3000);
            check("cv_dst", bus.npu_cmd_dst, 64'h4000);
            check("cv_stall", 64'(stall), 64'd1);
            tick();
            bus.npu_done = 1'b0;
        end
        check("cv_no_wb_from_stray_done", 64'(wb_valid), 64'd0);
        bus.npu_cmd_ready = 1'b1;
        tick();
        bus.npu_cmd_ready = 1'b0;
        check("cv_valid_after_hs", 64'(bus.npu_cmd_valid), 64'd0);
        check("cv_stall_wait", 64'(stall), 64'd1);
        bus.npu_done = 1'b1; bus.npu_result = 64'h55;
        tick();
        bus.npu_done = 1'b0;
        check("cv_wb_valid", 64'(wb_valid), 64'd1);
        check("cv_wb_rd", 64'(wb_rd), 64'd7);
        check("cv_wb_data", wb_data, 64'h55);
        tick();

        // Timeout: 8 WAIT cycles with no done.
        request(1'b1, 1'b0, 64'h10, 64'h20, 5'd3);
        bus.npu_cmd_ready = 1'b1;
        tick();
        drop_request();
        tick();
        bus.npu_cmd_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("to_no_wb_during_wait", 64'(wb_valid), 64'd0);
            check("to_stall", 64'(stall), 64'd1);
            tick();
        end
        check("to_wb_valid", 64'(wb_valid), 64'd1);
        check("to_wb_data", wb_data, 64'hFFFF_FFFF_FFFF_FFFF);
        check("to_fault", 64'(npu_fault), 64'd1);
        check("to_wb_rd", 64'(wb_rd), 64'd3);
        tick();
        check("to_fault_pulse", 64'(npu_fault), 64'd0);
        check("to_wb_pulse", 64'(wb_valid), 64'd0);

        // Done coincides with timeout expiry: done wins.
        request(1'b1, 1'b0, 64'h10, 64'h20, 5'd4);
        bus.npu_cmd_ready = 1'b1;
        tick();
        drop_request();
        tick();
        bus.npu_cmd_ready = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        bus.npu_done = 1'b1; bus.npu_result = 64'h77;
        tick();
        bus.npu_done = 1'b0;
        check("tie_wb_valid", 64'(wb_valid), 64'd1);
        check("tie_wb_data", wb_data, 64'h77);
        check("tie_fault", 64'(npu_fault), 64'd0);
        tick();

        // Error completion to rd = 0: fault without register write.
        request(1'b0, 1'b1, 64'h1, 64'h2, 5'd0);
        bus.npu_cmd_ready = 1'b1;
        tick();
        drop_request();
        tick();
        bus.npu_cmd_ready = 1'b0;
        bus.npu_done = 1'b1; bus.npu_error = 1'b1; bus.npu_result = 64'h99;
        tick();
        bus.npu_done = 1'b0; bus.npu_error = 1'b0;
        check("err_wb_valid", 64'(wb_valid), 64'd0);
        check("err_fault", 64'(npu_fault), 64'd1);
        check("err_wb_data", wb_data, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        check("err_fault_pulse", 64'(npu_fault), 64'd0);
        check("err_back_idle", 64'(stall), 64'd0);

        // Both flags set: ignored.
        request(1'b1, 1'b1, 64'h5, 64'h6, 5'd9);
        #1 check("both_stall", 64'(stall), 64'd0);
        tick();
        check("both_no_cmd", 64'(bus.npu_cmd_valid), 64'd0);
        check("both_stall_after", 64'(stall), 64'd0);
        drop_request();

        // Reset pulsed mid-WAIT: command abandoned, later done ignored.
        request(1'b1, 1'b0, 64'h8, 64'h9, 5'd9);
        bus.npu_cmd_ready = 1'b1;
        tick();
        drop_request();
        tick();
        bus.npu_cmd_ready = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("rstw_stall", 64'(stall), 64'd0);
        check("rstw_wb_valid", 64'(wb_valid), 64'd0);
        check("rstw_op", 64'(bus.npu_cmd_op), 64'd0);
        tick();
        rst_n = 1'b1;
        bus.npu_done = 1'b1; bus.npu_result = 64'h42;
        tick();
        bus.npu_done = 1'b0;
        check("rstw_no_wb", 64'(wb_valid), 64'd0);
        tick();
        check("rstw_no_wb2", 64'(wb_valid), 64'd0);
        check("rstw_idle", 64'(stall), 64'd0);

        // Reset during ISSUE drops npu_cmd_valid without waiting for a clock edge.
        request(1'b0, 1'b1, 64'hA, 64'hB, 5'd2);
        tick();
        drop_request();
        check("rsti_valid_before", 64'(bus.npu_cmd_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1 check("rsti_valid_async", 64'(bus.npu_cmd_valid), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/npu_dispatch.md
NPU_DISPATCH -- requirements
Module: npu_dispatch

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 1024, maximum WAIT-state cycles before the command is abandoned (legal range 2..65535).
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 dec_valid  in  1  a decoded instruction is present in EX this cycle.
REQ-005 is_npu_matrix_mul  in  1  decoder flag: NPU matrix-multiply instruction.
REQ-006 is_npu_conv  in  1  decoder flag: NPU convolution instruction.
REQ-007 rs1_data  in  64  source descriptor address.
REQ-008 rs2_data  in  64  destination descriptor address.
REQ-009 rd_addr  in  5  writeback register index.
REQ-010 stall  out  1  hold the pipeline front-end.
REQ-011 npu_cmd_valid  out  1  command offered to the NPU.
REQ-012 npu_cmd_ready  in  1  NPU accepts the command.
REQ-013 npu_cmd_op  out  2  01 = matrix-mul, 10 = convolution.
REQ-014 npu_cmd_src / npu_cmd_dst  out  64 each  latched rs1_data / rs2_data.
REQ-015 npu_done  in  1  NPU completion strobe.
REQ-016 npu_error  in  1  qualifies npu_done: operation failed.
REQ-017 npu_result  in  64  result, valid with npu_done.
REQ-018 wb_valid  out  1  one-cycle register-file write request.
REQ-019 wb_rd / wb_data  out  5 / 64  write index and data.
REQ-020 npu_fault  out  1  one-cycle pulse, coincident with the WB cycle, on error or timeout.

Function
REQ-021 The FSM SHALL have the states IDLE, ISSUE, WAIT and WB.
REQ-022 Request = dec_valid AND exactly one of the two NPU flags; both flags set SHALL be ignored: no dispatch, no stall.
REQ-023 IDLE: on a request, latch op, rs1_data, rs2_data and rd_addr, then go to ISSUE; otherwise stay in IDLE.
REQ-024 stall SHALL be combinational: high when state != IDLE, or when state is IDLE and a request is present.
REQ-025 ISSUE: npu_cmd_valid = 1 with op, src and dst held stable until npu_cmd_ready = 1; on that handshake go to WAIT and clear the cycle counter.
REQ-026 npu_done or npu_error seen while in IDLE or ISSUE SHALL be ignored.
REQ-027 WAIT: the counter increments each cycle. On npu_done, latch data (npu_result, or 64'hFFFF_FFFF_FFFF_FFFF if npu_error) and the fault flag (npu_error), then go to WB.
REQ-028 WAIT timeout: if the counter equals TIMEOUT_CYCLES-1 and npu_done = 0, latch data = all-ones and fault = 1, then go to WB. If npu_done and expiry coincide, done SHALL win.
REQ-029 WB: for exactly one cycle drive wb_valid = 1 if latched rd != 0 (0 otherwise), wb_rd = latched rd, wb_data = latched data, npu_fault = latched fault; then go to IDLE.
REQ-030 dec_valid SHALL be ignored outside IDLE; a new request in IDLE is accepted on the cycle after WB.
REQ-031 Minimum latency: acceptance at cycle 0, handshake at cycle 1, done at cycle 2, wb_valid at cycle 3.
REQ-032 The counter width SHALL be clog2(TIMEOUT_CYCLES+1) and the counter SHALL NOT wrap.

Reset
REQ-033 While rst_n = 0, state = IDLE and all registered outputs, latches and the counter SHALL be 0; npu_cmd_valid, wb_valid and npu_fault SHALL drop asynchronously.
REQ-034 Reset during ISSUE or WAIT SHALL abandon the command with no writeback; a later npu_done SHALL be ignored.
REQ-035 The first request SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-036 Matmul, rs1 = 0x1000, rs2 = 0x2000, rd = 5, ready = 1 immediately, done after 4 WAIT cycles with result 0xABCD -> op = 01, wb_valid pulses once, wb_rd = 5, wb_data = 0xABCD, npu_fault = 0.
REQ-037 Conv with ready low for 3 cycles -> npu_cmd_valid held with src, dst and op = 10 stable throughout, stall high from acceptance through WB.
REQ-038 TIMEOUT_CYCLES = 8, no done -> WB exactly 8 WAIT cycles after the handshake, wb_data = all-ones, npu_fault = 1.
REQ-039 done with error = 1, rd = 0 -> wb_valid = 0, npu_fault = 1 for one cycle, FSM returns to IDLE.
REQ-040 Both flags set -> no npu_cmd_valid, stall = 0. rst_n pulsed low mid-WAIT -> outputs 0 immediately, no wb_valid afterwards.
